// File: rtl/lsu.sv
// Load/store unit: one outstanding data-bus access, lane-aligned strobes/data, extended load writeback.
// Optional LSU_MISALIGN_CHECK_EN drops misaligned accesses and flags them on completion.
package common;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module lsu
    import common::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        done,
    output logic        done_wen,
    output logic [4:0]  done_rd,
    output logic [63:0] done_data,
    output logic        misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic        r_load;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [2:0]  r_off;
    logic [4:0]  r_rd;
    dbus_req_t   r_dreq;
    logic        r_done;
    logic        r_wen;
    logic [4:0]  r_drd;
    logic [63:0] r_ddata;
    logic        r_mis;

    logic [1:0]  w_size;
    logic [2:0]  w_off;
    logic [7:0]  w_base;
    logic [7:0]  w_strobe;
    logic [63:0] w_wdata;
    logic        w_misal;
    logic [63:0] w_shift;
    logic [63:0] w_ext;
    logic        w_unused;

    assign w_size   = req_funct3[1:0];
    assign w_off    = req_addr[2:0];
    assign w_strobe = w_base << w_off;
    assign w_wdata  = req_wdata << {w_off, 3'b000};
    assign w_shift  = dresp.data >> {r_off, 3'b000};
    assign w_unused = dresp.addr_ok;

    always_comb begin
        w_base = 8'h00;
        unique case (w_size)
            2'd0: w_base = 8'h01;
            2'd1: w_base = 8'h03;
            2'd2: w_base = 8'h0F;
            2'd3: w_base = 8'hFF;
            default: w_base = 8'h00;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic [2:0] w_amask;

    always_comb begin
        w_amask = 3'b000;
        unique case (w_size)
            2'd0: w_amask = 3'b000;
            2'd1: w_amask = 3'b001;
            2'd2: w_amask = 3'b011;
            2'd3: w_amask = 3'b111;
            default: w_amask = 3'b000;
        endcase
    end

    assign w_misal = |(w_off & w_amask);
`else
    assign w_misal = 1'b0;
`endif

    // Extension uses the latched size/sign, bus data is taken live on data_ok.
    always_comb begin
        w_ext = w_shift;
        unique case (r_size)
            2'd0: w_ext = r_uns ? {56'd0, w_shift[7:0]}
                                : {{56{w_shift[7]}}, w_shift[7:0]};
            2'd1: w_ext = r_uns ? {48'd0, w_shift[15:0]}
                                : {{48{w_shift[15]}}, w_shift[15:0]};
            2'd2: w_ext = r_uns ? {32'd0, w_shift[31:0]}
                                : {{32{w_shift[31]}}, w_shift[31:0]};
            2'd3: w_ext = w_shift;
            default: w_ext = w_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'd0;
            r_off   <= 3'd0;
            r_rd    <= 5'd0;
            r_dreq  <= '0;
            r_done  <= 1'b0;
            r_wen   <= 1'b0;
            r_drd   <= 5'd0;
            r_ddata <= 64'd0;
            r_mis   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_load <= req_load;
                        r_uns  <= req_funct3[2];
                        r_size <= w_size;
                        r_off  <= w_off;
                        r_rd   <= req_rd;
                        if (w_misal) begin
                            r_state <= S_RESP;
                            r_done  <= 1'b1;
                            r_mis   <= 1'b1;
                            r_wen   <= 1'b0;
                            r_drd   <= req_rd;
                            r_ddata <= 64'd0;
                        end else begin
                            r_state       <= S_BUS;
                            r_dreq.valid  <= 1'b1;
                            r_dreq.addr   <= req_addr;
                            r_dreq.size   <= {1'b0, w_size};
                            r_dreq.strobe <= req_load ? 8'h00 : w_strobe;
                            r_dreq.data   <= w_wdata;
                        end
                    end
                end
                S_BUS: begin
                    if (dresp.data_ok) begin
                        r_state      <= S_RESP;
                        r_dreq.valid <= 1'b0;
                        r_done       <= 1'b1;
                        r_wen        <= r_load;
                        r_drd        <= r_rd;
                        r_ddata      <= r_load ? w_ext : 64'd0;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_wen   <= 1'b0;
                    r_mis   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign dreq      = r_dreq;
    assign done      = r_done;
    assign done_wen  = r_wen;
    assign done_rd   = r_drd;
    assign done_data = r_ddata;
    assign misalign  = r_mis;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: per-cycle compare against a transaction-level timeline model.
module tb_lsu;
    import common::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        done;
    logic        done_wen;
    logic [4:0]  done_rd;
    logic [63:0] done_data;
    logic        misalign;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .dreq(dreq), .dresp(dresp),
        .done(done), .done_wen(done_wen), .done_rd(done_rd),
        .done_data(done_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    bit          m_en = 1'b0;
    logic        m_ready, m_dvalid, m_done, m_wen, m_mis;
    logic [4:0]  m_rd;
    logic [63:0] m_data, m_addr, m_wd;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [7:0] f_strobe(input logic ld, input logic [2:0] f3,
                                            input logic [63:0] a);
        int n;
        int off;
        logic [15:0] s;
        n = 1 << f3[1:0];
        off = int'(a % 8);
        s = ((16'd1 << n) - 16'd1) << off;
        if (ld) return 8'h00;
        return s[7:0];
    endfunction

    function automatic logic [63:0] f_wdata(input logic [63:0] a, input logic [63:0] wd);
        return wd << (8 * int'(a % 8));
    endfunction

    function automatic logic [63:0] f_load(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] rd);
        int n;
        logic [63:0] v;
        logic [63:0] mask;
        n = 1 << f3[1:0];
        v = rd >> (8 * int'(a % 8));
        if (n < 8) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            v = v & mask;
            if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic f_mis(input logic [2:0] f3, input logic [63:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return (a % (64'd1 << f3[1:0])) != 0;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_en) begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, m_ready});
            chk("dreq_valid", {63'd0, dreq.valid}, {63'd0, m_dvalid});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("done_wen", {63'd0, done_wen}, {63'd0, m_wen});
            chk("misalign", {63'd0, misalign}, {63'd0, m_mis});
            chk("done_rd", {59'd0, done_rd}, {59'd0, m_rd});
            chk("done_data", done_data, m_data);
            if (m_dvalid) begin
                chk("dreq_addr", dreq.addr, m_addr);
                chk("dreq_size", {61'd0, dreq.size}, {61'd0, m_size});
                chk("dreq_strobe", {56'd0, dreq.strobe}, {56'd0, m_strobe});
                chk("dreq_data", dreq.data, m_wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ready = 1'b1; m_dvalid = 1'b0; m_done = 1'b0;
        m_wen = 1'b0; m_mis = 1'b0; m_rd = 5'd0; m_data = 64'd0;
        m_addr = 64'd0; m_wd = 64'd0; m_size = 3'd0; m_strobe = 8'd0;
    endtask

    task automatic garbage_req();
        req_valid  = 1'($urandom);
        req_load   = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = rnd64();
        req_wdata  = rnd64();
        req_rd     = 5'($urandom);
    endtask

    // Drives one access; k = BUS cycles until data_ok is sampled (k >= 1).
    task automatic txn(input logic ld, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd,
                       input logic [63:0] rdata, input int k);
        req_valid = 1'b1; req_load = ld; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        dresp.data_ok = 1'($urandom);
        dresp.data = rnd64();
        tick();
        garbage_req();
        if (f_mis(f3, a)) begin
            m_ready = 1'b0; m_dvalid = 1'b0; m_done = 1'b1;
            m_wen = 1'b0; m_mis = 1'b1; m_rd = rd; m_data = 64'd0;
            dresp.data_ok = 1'($urandom);
            tick();
            m_ready = 1'b1; m_done = 1'b0; m_mis = 1'b0;
            req_valid = 1'b0;
            return;
        end
        m_ready = 1'b0; m_dvalid = 1'b1; m_done = 1'b0;
        m_addr = a; m_size = {1'b0, f3[1:0]};
        m_strobe = f_strobe(ld, f3, a); m_wd = f_wdata(a, wd);
        for (int i = 1; i <= k; i++) begin
            dresp.data_ok = (i == k);
            dresp.addr_ok = 1'($urandom);
            dresp.data = (i == k) ? rdata : rnd64();
            tick();
            garbage_req();
        end
        dresp.data_ok = 1'($urandom);
        dresp.data = rnd64();
        m_dvalid = 1'b0; m_done = 1'b1; m_wen = ld; m_rd = rd;
        m_data = ld ? f_load(f3, a, rdata) : 64'd0;
        tick();
        m_ready = 1'b1; m_done = 1'b0; m_wen = 1'b0;
        req_valid = 1'b0;
        dresp.data_ok = 1'b0;
    endtask

    task automatic idle(input int n, input logic spur);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            dresp.data_ok = spur;
            dresp.data = rnd64();
            tick();
        end
        dresp.data_ok = 1'b0;
    endtask

    task automatic rst_mid();
        req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b011;
        req_addr = 64'h8000_0010; req_wdata = 64'd0; req_rd = 5'd9;
        dresp.data_ok = 1'b0;
        tick();
        req_valid = 1'b0;
        m_ready = 1'b0; m_dvalid = 1'b1;
        m_addr = 64'h8000_0010; m_size = 3'd3; m_strobe = 8'h00; m_wd = 64'd0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        idle(3, 1'b1);
    endtask

    logic [63:0] r_wd, r_rdata;
    logic [2:0]  r_f3;
    logic        r_ld;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
        dresp = '0;
        model_reset();
        tick();
        tick();
        m_en = 1'b1;
        tick();
        rst = 1'b0;

        chk("pin_ld", f_load(3'b011, 64'h8000_0010, 64'h1122334455667788),
            64'h1122334455667788);
        chk("pin_lb", f_load(3'b000, 64'h8000_0003, 64'h00000000F0000000),
            64'hFFFFFFFFFFFFFFF0);
        chk("pin_lbu", f_load(3'b100, 64'h8000_0003, 64'h00000000F0000000),
            64'h00000000000000F0);
        chk("pin_sh_strobe", {56'd0, f_strobe(1'b0, 3'b001, 64'h8000_0006)}, 64'hC0);
        chk("pin_sh_data", f_wdata(64'h8000_0006, 64'hABCD), 64'hABCD000000000000);
        chk("pin_lw_strobe", {56'd0, f_strobe(1'b1, 3'b010, 64'h8000_0002)}, 64'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("pin_lw_mis", {63'd0, f_mis(3'b010, 64'h8000_0002)}, 64'd1);
`else
        chk("pin_lw_mis", {63'd0, f_mis(3'b010, 64'h8000_0002)}, 64'd0);
`endif

        txn(1'b1, 3'b011, 64'h8000_0010, rnd64(), 5'd7, 64'h1122334455667788, 3);
        idle(1, 1'b0);
        txn(1'b1, 3'b000, 64'h8000_0003, rnd64(), 5'd3, 64'h00000000F0000000, 2);
        txn(1'b1, 3'b100, 64'h8000_0003, rnd64(), 5'd4, 64'h00000000F0000000, 1);
        txn(1'b0, 3'b001, 64'h8000_0006, 64'hABCD, 5'd5, rnd64(), 2);
        idle(2, 1'b1);
        txn(1'b0, 3'b010, 64'h8000_0004, 64'hDEADBEEF, 5'd6, rnd64(), 1);
        rst_mid();
        txn(1'b1, 3'b010, 64'h8000_0002, rnd64(), 5'd8, 64'h0123456789ABCDEF, 2);
        txn(1'b1, 3'b111, 64'h8000_0008, rnd64(), 5'd0, 64'hFEDCBA9876543210, 1);

        for (int t = 0; t < 300; t++) begin
            r_ld = 1'($urandom);
            r_f3 = r_ld ? 3'($urandom) : {1'b0, 2'($urandom)};
            r_wd = rnd64();
            r_rdata = rnd64();
            txn(r_ld, r_f3, rnd64(), r_wd, 5'($urandom), r_rdata,
                int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), 1'($urandom));
            if (t == 150) rst_mid();
        end

        idle(2, 1'b0);
        m_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
